// File: rtl/mems_scan_pkg.sv
// -----------------------------------------------------------------------------
// mems_scan_pkg
// Shared definitions for the MEMS scan path: DAC update FSM states, channel
// select, DAC command bytes and the 24-bit SPI frame layout.
// -----------------------------------------------------------------------------
package mems_scan_pkg;

    // SPI frame: {command[7:0], sample[15:0]}, shifted MSB first.
    localparam int DAC_FRAME_W = 24;

    // Write input register and update: channel A carries X, channel B carries Y.
    localparam logic [7:0] DAC_CMD_X = 8'h18;
    localparam logic [7:0] DAC_CMD_Y = 8'h19;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_ROM,
        ST_SHIFT,
        ST_SETTLE,
        ST_DONE
    } dac_state_t;

    typedef enum logic {
        CH_X = 1'b0,
        CH_Y = 1'b1
    } dac_chan_t;

    // Assemble the frame for one channel; the ROM word passes through untouched.
    function automatic logic [DAC_FRAME_W-1:0] dac_frame(input dac_chan_t  ch,
                                                         input logic [15:0] word);
        return {(ch == CH_Y) ? DAC_CMD_Y : DAC_CMD_X, word};
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// -----------------------------------------------------------------------------
// spi_tx_shifter
// Sends one 24-bit frame MSB first. SCLK idles high and toggles every CLK_DIV
// clk cycles; data changes only on SCLK rising edges so the DAC can sample on
// the falling edge. A frame is 48 half-periods (24 falling edges).
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   load       : one-cycle strobe; captures frame and starts shifting
//   frame      : 24-bit word to send
//   sclk       : SPI clock (registered, idles high)
//   sync_n     : frame select (registered, active low)
//   din        : serial data (registered)
//   done       : high in the last shifting cycle; the edge ending it raises
//                sclk and sync_n together
// -----------------------------------------------------------------------------
module spi_tx_shifter
    import mems_scan_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DAC_FRAME_W-1:0] frame,
    output logic                   sclk,
    output logic                   sync_n,
    output logic                   din,
    output logic                   done
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_N = 2 * DAC_FRAME_W;

    logic                   active;
    logic [DIV_W-1:0]       div_cnt;
    logic [5:0]             half_cnt;
    logic [DAC_FRAME_W-1:0] shreg;
    logic                   half_end;

    assign half_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign done     = half_end && (half_cnt == 6'(HALF_N - 1));

    // NOTE: every register here, the shift register included, takes the async
    // reset so a reset mid-frame leaves no trace of the discarded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= '0;
            sclk     <= 1'b1;
            sync_n   <= 1'b1;
            din      <= 1'b0;
        end else if (load) begin
            // First bit is presented with sync_n falling; SCLK stays high.
            active   <= 1'b1;
            div_cnt  <= '0;
            half_cnt <= '0;
            shreg    <= {frame[DAC_FRAME_W-2:0], 1'b0};
            sclk     <= 1'b1;
            sync_n   <= 1'b0;
            din      <= frame[DAC_FRAME_W-1];
        end else if (active) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge
            // values, so shreg and din shift in lockstep without ordering hazards.
            if (half_end) begin
                div_cnt  <= '0;
                half_cnt <= half_cnt + 6'd1;
                if (!half_cnt[0]) begin
                    // End of a high phase: falling edge, DAC samples din.
                    sclk <= 1'b0;
                end else begin
                    sclk <= 1'b1;
                    if (done) begin
                        // Final rise closes the frame.
                        active <= 1'b0;
                        sync_n <= 1'b1;
                        din    <= 1'b0;
                    end else begin
                        din   <= shreg[DAC_FRAME_W-1];
                        shreg <= {shreg[DAC_FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mems_dac_spi.sv
// -----------------------------------------------------------------------------
// mems_dac_spi
// Takes X/Y start requests from the scan arbiter, waits for the addressed ROM
// word, sends it to the dual DAC as one SPI write-and-update frame (X -> ch A,
// Y -> ch B), waits for the mirror to settle and pulses dac_finish_flag.
//
// Ports
//   clk, rst_n         : system clock, asynchronous active-low reset
//   x_start_flag       : level request for an X update (wins over Y)
//   y_start_flag       : level request for a Y update
//   x_rom_data         : X sample, valid ROM_LAT cycles after acceptance
//   y_rom_data         : Y sample, same timing
//   dac_sclk           : SPI clock, idles high
//   dac_sync_n         : SPI frame select, active low
//   dac_din            : SPI data, MSB first
//   dac_finish_flag    : one-cycle pulse when the update is complete
//   busy               : high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mems_dac_spi
    import mems_scan_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int ROM_LAT       = 2,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        x_start_flag,
    input  logic        y_start_flag,
    input  logic [15:0] x_rom_data,
    input  logic [15:0] y_rom_data,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
    output logic        dac_finish_flag,
    output logic        busy
);

    // One counter serves both the ROM wait and the settle wait.
    localparam int CNT_MAX = (ROM_LAT > SETTLE_CYCLES) ? ROM_LAT : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    dac_state_t             state;
    dac_chan_t              chan;
    logic [CNT_W-1:0]       cnt;
    logic                   load;
    logic                   shift_done;
    logic [DAC_FRAME_W-1:0] frame;

    // The last WAIT_ROM cycle is when the ROM word is valid; capture it then.
    assign load  = (state == ST_WAIT_ROM) && (cnt == CNT_W'(ROM_LAT - 1));
    assign frame = dac_frame(chan, (chan == CH_Y) ? y_rom_data : x_rom_data);

    spi_tx_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .frame  (frame),
        .sclk   (dac_sclk),
        .sync_n (dac_sync_n),
        .din    (dac_din),
        .done   (shift_done)
    );

    // Request FSM. Start flags are only looked at in IDLE, so a flag the
    // arbiter still holds during SHIFT/SETTLE/DONE never starts a second frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            chan            <= CH_X;
            cnt             <= '0;
            dac_finish_flag <= 1'b0;
            busy            <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    dac_finish_flag <= 1'b0;
                    if (x_start_flag || y_start_flag) begin
                        // X has priority; a simultaneous Y is not remembered.
                        chan  <= x_start_flag ? CH_X : CH_Y;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_WAIT_ROM;
                    end
                end
                ST_WAIT_ROM: begin
                    if (load) begin
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_done) begin
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        dac_finish_flag <= 1'b1;
                        state           <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    dac_finish_flag <= 1'b0;
                    busy            <= 1'b0;
                    state           <= ST_IDLE;
                end
                default: begin
                    dac_finish_flag <= 1'b0;
                    busy            <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mems_dac_spi.md
# mems_dac_spi

Downstream stage of the MEMS scan arbiter. It consumes the X/Y start flags and the ROM sample words the arbiter addresses, and serialises each sample as one 24-bit SPI write-and-update frame to a dual-channel 16-bit DAC: X goes to channel A, Y to channel B. After a programmable mirror settle time it returns the single-cycle `dac_finish_flag` that advances the arbiter to the next axis.

## Interface
- `CLK_DIV`, 4 — SCLK half-period in `clk` cycles; minimum 1.
- `ROM_LAT`, 2 — cycles from start-flag acceptance to valid ROM data; minimum 1.
- `SETTLE_CYCLES`, 100 — cycles between frame end and finish pulse; minimum 1.
- `clk`  in  1  system clock; everything runs in this single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `x_start_flag`  in  1  level; request an X-axis (channel A) update.
- `y_start_flag`  in  1  level; request a Y-axis (channel B) update.
- `x_rom_data`  in  16  X sample word, valid `ROM_LAT` cycles after acceptance.
- `y_rom_data`  in  16  Y sample word, same timing.
- `dac_sclk`  out  1  SPI clock; idles high.
- `dac_sync_n`  out  1  frame select; active low.
- `dac_din`  out  1  serial data, MSB first.
- `dac_finish_flag`  out  1  one-cycle pulse at the end of each update.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: wait for a start flag.
  - WAIT_ROM: `ROM_LAT` cycles; latch `{cmd, data}` into the 24-bit shift register on the last cycle.
  - SHIFT: `48*CLK_DIV` cycles.
  - SETTLE: `SETTLE_CYCLES` cycles.
  - DONE: 1 cycle, then back to IDLE.
- In IDLE, either start flag high means accept, register the selected channel, and go to WAIT_ROM.
- If both flags are high in the same cycle, X wins; Y is not queued.
- Start flags are ignored in every state except IDLE. The arbiter holds its start flag high until finish; this is legal and must not cause a second frame.
- The arbiter drops the old flag in the cycle after DONE. Because DONE is never IDLE, that stale flag is never re-accepted.
- Frame bits [23:16] are the command byte: 8'h18 for channel A/X, 8'h19 for channel B/Y (write input register and update). Bits [15:0] are the latched ROM word, unmodified.
- SHIFT, per bit:
  - `dac_din` changes only while `dac_sclk` is high or on its rising edge.
  - The DAC samples on the falling edge.
  - There are exactly 24 falling edges per frame.
- SETTLE: `dac_sync_n` = 1 and `dac_sclk` = 1; nothing is driven.
- DONE: `dac_finish_flag` = 1 for exactly one cycle.
- Reset mid-frame: all outputs return immediately to reset values, the FSM goes to IDLE, and the partial frame is discarded. A new request after reset is a clean frame.
- Reset values: `dac_sclk`=1, `dac_sync_n`=1, `dac_din`=0, `dac_finish_flag`=0, `busy`=0, FSM = IDLE.
- All outputs are registered.

## Timing
- Start flag sampled high in IDLE at edge k:
  - WAIT_ROM occupies cycles k+1 .. k+ROM_LAT.
  - SHIFT starts at cycle k+ROM_LAT+1.
- SHIFT cycle 0: `dac_sync_n` falls, `dac_din` = bit 23, `dac_sclk` = 1.
- `dac_sclk` toggles every `CLK_DIV` cycles:
  - falling edge n (n = 0..23) at SHIFT offset (2n+1)·CLK_DIV;
  - `dac_din` advances to the next bit on each rising edge at offset 2n·CLK_DIV, n ≥ 1.
- `dac_sync_n` rises on the first SETTLE cycle, together with the final `dac_sclk` rise.
- `dac_finish_flag` is high in cycle k+ROM_LAT+48·CLK_DIV+SETTLE_CYCLES+1. With defaults that is k+295.
- A new request can be accepted at the earliest in the cycle after DONE, giving a back-to-back period of 1+ROM_LAT+48·CLK_DIV+SETTLE_CYCLES+1 cycles.

## Structure
- Shared package `mems_scan_pkg`:
  - FSM state encoding;
  - command constants `DAC_CMD_X`=8'h18 and `DAC_CMD_Y`=8'h19;
  - `DAC_FRAME_W`=24.
- One natural sub-module, `spi_tx_shifter`:
  - takes a 24-bit load, `CLK_DIV` divider, SCLK generation and bit counter;
  - returns a `done` strobe.
- The top level keeps the request FSM, the ROM wait and settle counters, and the finish pulse.

## Test plan
- Reset, then `x_start_flag`=1 held with `x_rom_data`=16'hA5C3 → decoded frame 24'h18A5C3 (24 falling edges), then one finish pulse at k+295, then no second frame while the flag stays high through the DONE cycle.
- Arbiter-style ping-pong: finish drops X and raises Y the next cycle, `y_rom_data`=16'h0001 → frame 24'h190001 starts at the expected offset; frames alternate for 10 updates.
- `x_start_flag` and `y_start_flag` rise in the same cycle → only the channel-A frame is sent; Y is served only if still high after DONE.
- `rst_n` pulsed low during SHIFT bit 10 → outputs go to reset values immediately and there is no finish pulse; the next request produces a full, correct 24-bit frame.
- `CLK_DIV`=1, `ROM_LAT`=1, `SETTLE_CYCLES`=1 → frame 48 cycles long and finish at k+51; DAC model decodes the data correctly.
- Data extremes 16'h0000 and 16'hFFFF on both channels → the exact words are received, and `dac_din` never changes while `dac_sclk` is low.
